fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Upstream control stage for ALU_reg: fetches one 32-bit instruction per step from memory.
//  Holds the fetched word stable on `instruction` and drives ALU_reg's active-low enable_n.
//  Strobes register-file writeback, then advances the PC.
//  Multi-cycle, unpipelined. One instruction is in flight at a time.
// PARAMETERS
//  XLEN         32        datapath/address width
//  RESET_PC     32'h0     PC value loaded on reset
//  EXEC_CYCLES  2         cycles enable_n is held low before writeback (>=2)
// PORTS
//  clk               in   1     system clock, rising-edge
//  rst_n             in   1     reset, asynchronous assert, active-low
//  run               in   1     1 = sequencer may start a new fetch
//  mem_addr          out  XLEN  instruction fetch address (= pc)
//  mem_req           out  1     fetch request, held until mem_ack
//  mem_ack           in   1     fetch complete; mem_rdata valid this cycle
//  mem_rdata         in   XLEN  fetched instruction word
//  instruction       out  XLEN  instruction register, to ALU_reg
//  alu_reg_enable_n  out  1     0 = ALU_reg active
//  wb_en             out  1     1-cycle strobe: register file captures ALU_reg output
//  pc                out  XLEN  current PC (debug)
//  fault             out  1     sticky: illegal opcode fetched
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, instruction=0, mem_req=0, alu_reg_enable_n=1, wb_en=0, fault=0.
//  State machine: IDLE, FETCH, DECODE, EXEC, WB, TRAP.
//  IDLE:   run=1 -> FETCH next cycle; else stay in IDLE.
//  FETCH:  mem_req=1, mem_addr=pc.
//          - On mem_ack: instruction<=mem_rdata, go to DECODE.
//          - Ack may arrive in the first FETCH cycle; minimum fetch latency is 1 cycle.
//          - mem_req drops in the cycle after ack.
//  DECODE: classify instruction[6:0].
//          - 7'b0110011 (OP) -> EXEC.
//          - Any other opcode -> TRAP, fault<=1.
//  EXEC:   alu_reg_enable_n=0 for exactly EXEC_CYCLES cycles, counted by cycle_cnt, then WB.
//  WB:     alu_reg_enable_n=0, wb_en=1 for 1 cycle.
//          - pc<=pc+4, modulo 2^XLEN; 32'hFFFFFFFC wraps to 0.
//          - Then run=1 -> FETCH, else IDLE.
//  TRAP:   absorbing until reset.
//          - mem_req=0, alu_reg_enable_n=1, wb_en=0, fault=1, pc frozen at faulting address.
//  Outside EXEC/WB: alu_reg_enable_n=1.
//  instruction changes only on the FETCH ack edge; it is stable from DECODE through WB.
//  mem_ack outside FETCH is ignored.
//  run is sampled only in IDLE and WB. Deasserting run mid-instruction completes that instruction.
//  Instruction step latency (idle, ack in first cycle): 1 FETCH + 1 DECODE + EXEC_CYCLES + 1 WB.
//    Default: 5 cycles.
//  rst_n low at any time, including mid-FETCH, mid-EXEC or TRAP:
//    all outputs return to reset values immediately (asynchronous); no writeback occurs.
//  All outputs are registered; none is combinational from inputs.
// STRUCTURE
//  cpu_pkg (shared): XLEN, REG_SELECT_LEN, opcode constants (OPC_OP=7'b0110011),
//    seq_state_t enum.
//  Opcode classifier is small; keep it inline. No sub-module.
// TESTING
//  1. Reset, run=1, mem_ack in first FETCH cycle, rdata=32'h00B50533:
//     - enable_n low for cycles 3-5; wb_en high cycle 5.
//     - pc=4 after; mem_req reasserts cycle 6.
//  2. mem_ack delayed 4 cycles:
//     - mem_req held high 4 cycles at mem_addr=0.
//     - instruction unchanged until ack; enable_n stays 1.
//  3. rdata=32'h00000013 (OP-IMM):
//     - TRAP; fault=1 and sticky; mem_req=0; pc=0.
//     - After rst_n pulse: fault=0, pc=RESET_PC.
//  4. RESET_PC=32'hFFFFFFFC, one legal instruction -> after WB pc=32'h00000000.
//  5. Assert rst_n=0 mid-EXEC:
//     - enable_n=1 and wb_en=0 asynchronously, before next edge.
//     - No wb_en pulse is ever observed.
//  6. run dropped during EXEC:
//     - WB completes, pc+=4, state IDLE.
//     - Spurious mem_ack while idle has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode constants and sequencer states.
package cpu_pkg;

  localparam int XLEN           = 32;
  localparam int REG_SELECT_LEN = 5;

  // RV32 major opcode for register-register ALU operations
  localparam logic [6:0] OPC_OP = 7'b0110011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } seq_state_t;

endpackage : cpu_pkg

// File: rtl/fetch_sequencer.sv
// Multi-cycle, unpipelined fetch/decode/execute/writeback sequencer driving ALU_reg.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | waiting for run; PC holds the next fetch address
//  FETCH  | mem_req high at mem_addr=pc until mem_ack captures the word
//  DECODE | classify instruction[6:0]; OP continues, anything else traps
//  EXEC   | ALU_reg enabled for EXEC_CYCLES cycles (down-counter)
//  WB     | ALU_reg still enabled, wb_en strobe, pc advances by 4
//  TRAP   | illegal opcode; everything quiet, fault sticky until reset
//
// Every output is a flop. Output flops are loaded from the next state so they
// line up with the state register without any combinational path from inputs.
module fetch_sequencer #(
  parameter int              XLEN        = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              EXEC_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic            alu_reg_enable_n,
  output logic            wb_en,
  output logic [XLEN-1:0] pc,
  output logic            fault
);

  import cpu_pkg::*;

  // EXEC_CYCLES >= 2, so this width is at least 1 and holds EXEC_CYCLES-1
  localparam int               CNT_W    = $clog2(EXEC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  seq_state_t       state, state_nx;
  logic [CNT_W-1:0] cycle_cnt, cycle_cnt_nx;

  // Next-state logic; the EXEC timer is loaded on entry and ends at terminal count zero
  always_comb begin
    state_nx     = state;
    cycle_cnt_nx = cycle_cnt;
    case (state)
      S_IDLE: begin
        if (run) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (instruction[6:0] == OPC_OP) begin
          state_nx     = S_EXEC;
          cycle_cnt_nx = CNT_LOAD;
        end else begin
          state_nx = S_TRAP;
        end
      end
      S_EXEC: begin
        if (cycle_cnt == '0) state_nx = S_WB;
        else                 cycle_cnt_nx = cycle_cnt - CNT_W'(1);
      end
      S_WB: begin
        state_nx = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        state_nx = S_TRAP;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, timer, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cycle_cnt        <= '0;
      pc               <= RESET_PC;
      instruction      <= '0;
      mem_req          <= 1'b0;
      alu_reg_enable_n <= 1'b1;
      wb_en            <= 1'b0;
      fault            <= 1'b0;
    end else begin
      state            <= state_nx;
      cycle_cnt        <= cycle_cnt_nx;
      mem_req          <= (state_nx == S_FETCH);
      alu_reg_enable_n <= !((state_nx == S_EXEC) || (state_nx == S_WB));
      wb_en            <= (state_nx == S_WB);
      if (state == S_FETCH && mem_ack) instruction <= mem_rdata;
      // PC moves at the end of WB so it stays at the instruction's own address until then
      if (state == S_WB) pc <= pc + XLEN'(4);
      if (state_nx == S_TRAP) fault <= 1'b1;
    end
  end

  assign mem_addr = pc;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: default instance plus a RESET_PC=FFFFFFFC instance.
module tb_fetch_sequencer;

  localparam logic [31:0] ADD1  = 32'h00B50533;
  localparam logic [31:0] ADD2  = 32'h00C58633;
  localparam logic [31:0] OPIMM = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        run = 1'b0, mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_addr, instruction, pc;
  logic        mem_req, en_n, wb_en, fault;

  logic        run2 = 1'b0, mem_ack2 = 1'b0;
  logic [31:0] mem_rdata2 = '0;
  logic [31:0] mem_addr2, instruction2, pc2;
  logic        mem_req2, en_n2, wb_en2, fault2;

  int n_cmp = 0;
  int n_mis = 0;

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instruction(instruction), .alu_reg_enable_n(en_n), .wb_en(wb_en),
    .pc(pc), .fault(fault)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .run(run2),
    .mem_addr(mem_addr2), .mem_req(mem_req2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
    .instruction(instruction2), .alu_reg_enable_n(en_n2), .wb_en(wb_en2),
    .pc(pc2), .fault(fault2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Status of the default instance when nothing is happening in the ALU path
  task automatic check_quiet(input string tag, input logic req, input logic [31:0] p);
    check({tag, ".mem_req"}, {31'b0, mem_req}, {31'b0, req});
    check({tag, ".en_n"},    {31'b0, en_n},    32'd1);
    check({tag, ".wb_en"},   {31'b0, wb_en},   32'd0);
    check({tag, ".pc"},      pc,               p);
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    check("rst.pc", pc, 32'h0);
    check("rst.instr", instruction, 32'h0);
    check("rst.fault", {31'b0, fault}, 32'd0);
    check_quiet("rst", 1'b0, 32'h0);
    check("rst.pc2", pc2, 32'hFFFFFFFC);
    rst_n = 1'b1;

    // ---------------- 1: ack in first FETCH cycle ----------------
    run = 1'b1; mem_ack = 1'b1; mem_rdata = ADD1;
    tick();                                          // cycle 1: FETCH
    check("t1.c1.mem_req", {31'b0, mem_req}, 32'd1);
    check("t1.c1.mem_addr", mem_addr, 32'h0);
    check("t1.c1.en_n", {31'b0, en_n}, 32'd1);
    tick(); mem_ack = 1'b0;                          // cycle 2: DECODE
    check("t1.c2.instr", instruction, ADD1);
    check_quiet("t1.c2", 1'b0, 32'h0);
    tick();                                          // cycle 3: EXEC
    check("t1.c3.en_n", {31'b0, en_n}, 32'd0);
    check("t1.c3.wb_en", {31'b0, wb_en}, 32'd0);
    tick();                                          // cycle 4: EXEC
    check("t1.c4.en_n", {31'b0, en_n}, 32'd0);
    check("t1.c4.wb_en", {31'b0, wb_en}, 32'd0);
    tick();                                          // cycle 5: WB
    check("t1.c5.en_n", {31'b0, en_n}, 32'd0);
    check("t1.c5.wb_en", {31'b0, wb_en}, 32'd1);
    check("t1.c5.instr", instruction, ADD1);
    tick();                                          // cycle 6: FETCH again
    check_quiet("t1.c6", 1'b1, 32'h4);
    check("t1.c6.mem_addr", mem_addr, 32'h4);

    // ---------------- 2: delayed ack, then 6: run dropped in EXEC ----------------
    rst_n = 1'b0; #1; rst_n = 1'b1;
    check("t2.rst.pc", pc, 32'h0);
    tick();                                          // FETCH, ack low
    for (int i = 0; i < 4; i++) begin
      check("t2.hold.mem_req", {31'b0, mem_req}, 32'd1);
      check("t2.hold.mem_addr", mem_addr, 32'h0);
      check("t2.hold.instr", instruction, 32'h0);
      check("t2.hold.en_n", {31'b0, en_n}, 32'd1);
      if (i < 3) tick();
    end
    mem_ack = 1'b1; mem_rdata = ADD2;
    tick(); mem_ack = 1'b0; mem_rdata = OPIMM;       // DECODE
    check("t2.ack.instr", instruction, ADD2);
    check("t2.ack.mem_req", {31'b0, mem_req}, 32'd0);
    tick(); run = 1'b0;                              // EXEC 1
    check("t6.exec.en_n", {31'b0, en_n}, 32'd0);
    tick();                                          // EXEC 2
    tick();                                          // WB
    check("t6.wb.wb_en", {31'b0, wb_en}, 32'd1);
    tick();                                          // IDLE
    check_quiet("t6.idle", 1'b0, 32'h4);
    mem_ack = 1'b1;
    tick(); tick();
    check_quiet("t6.spur", 1'b0, 32'h4);
    check("t6.spur.instr", instruction, ADD2);
    check("t6.spur.fault", {31'b0, fault}, 32'd0);
    mem_ack = 1'b0;

    // ---------------- 5: reset mid-EXEC ----------------
    run = 1'b1; mem_ack = 1'b1; mem_rdata = ADD1;
    tick();                                          // FETCH
    tick(); mem_ack = 1'b0; run = 1'b0;              // DECODE
    tick();                                          // EXEC
    check("t5.exec.en_n", {31'b0, en_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t5.async.en_n", {31'b0, en_n}, 32'd1);
    check("t5.async.wb_en", {31'b0, wb_en}, 32'd0);
    check("t5.async.pc", pc, 32'h0);
    check("t5.async.instr", instruction, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5.after.wb_en", {31'b0, wb_en}, 32'd0);
    end
    check_quiet("t5.after", 1'b0, 32'h0);

    // ---------------- 3: illegal opcode traps ----------------
    run = 1'b1; mem_ack = 1'b1; mem_rdata = OPIMM;
    tick();                                          // FETCH
    tick(); mem_ack = 1'b0;                          // DECODE
    check("t3.dec.instr", instruction, OPIMM);
    tick();                                          // TRAP
    check("t3.trap.fault", {31'b0, fault}, 32'd1);
    check_quiet("t3.trap", 1'b0, 32'h0);
    mem_ack = 1'b1; mem_rdata = ADD1;
    tick(); tick(); tick();
    check("t3.sticky.fault", {31'b0, fault}, 32'd1);
    check("t3.sticky.instr", instruction, OPIMM);
    check_quiet("t3.sticky", 1'b0, 32'h0);
    mem_ack = 1'b0; run = 1'b0;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    check("t3.rst.fault", {31'b0, fault}, 32'd0);
    check("t3.rst.pc", pc, 32'h0);
    check("t3.rst.pc2", pc2, 32'hFFFFFFFC);

    // ---------------- 4: PC wrap on the second instance ----------------
    run2 = 1'b1; mem_ack2 = 1'b1; mem_rdata2 = ADD1;
    tick();                                          // FETCH
    check("t4.fetch.mem_addr", mem_addr2, 32'hFFFFFFFC);
    check("t4.fetch.mem_req", {31'b0, mem_req2}, 32'd1);
    tick(); mem_ack2 = 1'b0; run2 = 1'b0;            // DECODE
    tick(); tick();                                  // EXEC x2
    tick();                                          // WB
    check("t4.wb.wb_en", {31'b0, wb_en2}, 32'd1);
    check("t4.wb.pc", pc2, 32'hFFFFFFFC);
    tick();                                          // IDLE
    check("t4.idle.pc", pc2, 32'h0);
    check("t4.idle.mem_req", {31'b0, mem_req2}, 32'd0);
    check("t4.idle.fault", {31'b0, fault2}, 32'd0);
    check("t4.idle.wb_en", {31'b0, wb_en2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_fetch_sequencer
